video_downscaler_nxn: RTL and testbench
=======================================

Name: video_downscaler_nxn

Overview:
- Synthesizable streaming video downscaler; box-filters each FxF pixel block into one output pixel, where F = 2**SCALE_LOG2.
- Sits between the capture stream and the frame writer.
- Uses AXI-Stream-style valid/ready on both sides, with tuser = start-of-frame and tlast = end-of-line.
- Generalises the fixed 2x2 push/pop downscaler to a parametrised factor, selectable rounding, real backpressure and mid-frame resynchronisation.

Parameters:
- D_WIDTH, 8, pixel width in bits.
- SCALE_LOG2, 1, log2 of scale factor F per axis; legal range 1..3.
- MAX_WIDTH, 1024, maximum input line length in pixels; must be a multiple of F.
- ROUND, 0, output rounding: 0 = truncate, 1 = round-half-up.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), released synchronously to clk.
- up_data  in  D_WIDTH  input pixel.
- up_tuser  in  1  start-of-frame marker.
- up_tlast  in  1  end-of-line marker.
- up_valid  in  1  input beat valid.
- up_ready  out  1  block accepts input beat.
- down_data  out  D_WIDTH  averaged output pixel.
- down_tuser  out  1  first output pixel of frame.
- down_tlast  out  1  last output pixel of output line.
- down_valid  out  1  output beat valid.
- down_ready  in  1  downstream accepts output beat.
- framelock  out  1  high once the first start-of-frame has been seen.

Behaviour:
- Beat transfer: input beat transfers when up_valid & up_ready; output beat when down_valid & down_ready.
- Reset (rst=0): down_valid, down_data, down_tuser, down_tlast and framelock = 0. All counters = 0. Line-buffer contents are don't-care. Reset mid-frame discards all partial sums.
- Ready rule: up_ready = ~down_valid | down_ready (single output register; no combinational path from up_valid to up_ready).
- Lock: beats before the first up_tuser are accepted and dropped. An accepted beat with up_tuser=1 sets framelock, which stays 1 until reset.
- Counters:
  - px_cnt (0..F-1): pixel within horizontal group.
  - col (0..MAX_WIDTH/F-1): output column.
  - row_cnt (0..F-1): line within vertical group.
- Horizontal accumulation: hsum register, width D_WIDTH+SCALE_LOG2. It is loaded on px_cnt=0 and added to otherwise.
- Group write: when px_cnt=F-1, the line buffer entry at col (width D_WIDTH+2*SCALE_LOG2, depth MAX_WIDTH/F) is:
  - written with hsum+pixel when row_cnt=0 (this implicitly clears stale data);
  - read-modify-written with the accumulated value otherwise.
  - Then col increments.
- Flag accumulation: per-column tuser/tlast flags are accumulated alongside the sums by OR.
- Output: when px_cnt=F-1 and row_cnt=F-1, the full sum S is formed.
  - Result = S >> (2*SCALE_LOG2), or (S + 2**(2*SCALE_LOG2-1)) >> (2*SCALE_LOG2) when ROUND=1.
  - The rounding add is done at extended width, so no overflow occurs: all-max input gives all-max output.
  - Result is registered into down_data with down_valid=1 on the next cycle (latency 1 clk from the completing input beat).
  - down_tuser = OR of tusers in the block; down_tlast = OR of tlasts in the block.
- End of line (accepted up_tlast): px_cnt and col return to 0; row_cnt increments, wrapping F-1 -> 0.
  - If px_cnt != F-1 at tlast, the partial horizontal group is discarded: no write, no output.
- Mid-frame resync: up_tuser while locked and not at px_cnt=0/col=0/row_cnt=0 forces all counters to 0 before that beat is processed. The beat becomes pixel (0,0) of a new frame; prior partial blocks produce no output.
- Column overflow: if col would exceed MAX_WIDTH/F-1 before tlast, further groups on that line are dropped until tlast.
- Stall: while down_valid & ~down_ready, down_* hold stable and up_ready=0; no state advances.
- Simultaneous events: down transfer and a new block completion in the same cycle load the new result with down_valid kept 1 (full throughput, one output per F*F inputs).

Test Plan:
- Lock: SCALE_LOG2=1, D_WIDTH=8, ROUND=0. Send 3 beats without tuser, then a 4x2 frame (tuser on first, tlast on pixels 3 and 7) with values 10,20,30,40 / 50,60,70,80 -> exactly 2 outputs: 35 (tuser=1, tlast=0) then 55 (tuser=0, tlast=1). framelock rises on the tuser beat.
- Rounding: block 1,2,2,2 -> ROUND=0 gives 1, ROUND=1 gives 2. Block of all 255 with ROUND=1 -> 255.
- Factor 4: SCALE_LOG2=2, 8x4 frame, all pixels 100 except one 116 -> outputs 101 and 100, with tlast on the second output.
- Backpressure: hold down_ready=0 for 5 cycles after down_valid -> up_ready=0, down_* stable. Release -> no loss or duplication over a 16x16 random frame; results match a software reference model.
- Resync: tuser injected at pixel 5 of line 1 of an 8x2 frame -> no output for the aborted blocks; the next frame's first output has tuser=1 and correct averages.
- Reset: rst=0 asserted mid-line with down_valid=1 -> down_valid=0 immediately (asynchronous), framelock=0; stream after release requires a new tuser before any output.

Source files
------------

// File: rtl/video_downscaler_nxn.sv
// rtl/video_downscaler_nxn.sv - streaming FxF box-filter video downscaler
// Line buffer holds per-column partial vertical sums; one registered output beat.
module video_downscaler_nxn #(
  parameter int D_WIDTH    = 8,
  parameter int SCALE_LOG2 = 1,
  parameter int MAX_WIDTH  = 1024,
  parameter int ROUND      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_tuser,
  input  logic               up_tlast,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_tuser,
  output logic               down_tlast,
  output logic               down_valid,
  input  logic               down_ready,
  output logic               framelock
);
  localparam int F    = 1 << SCALE_LOG2;
  localparam int NCOL = MAX_WIDTH / F;
  localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int HW   = D_WIDTH + SCALE_LOG2;
  localparam int SW   = D_WIDTH + 2 * SCALE_LOG2;
  localparam logic [SCALE_LOG2-1:0] LAST = SCALE_LOG2'(F - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);
  localparam logic [SW-1:0] HALF = (ROUND != 0) ? (SW'(1) << (2 * SCALE_LOG2 - 1)) : '0;

  logic [SCALE_LOG2-1:0] px_cnt, row_cnt, px_e, row_e;
  logic [CW-1:0]         col, col_e;
  logic                  col_ovf, ovf_e;
  logic [HW-1:0]         hsum, hsum_n;
  logic                  h_tuser, h_tlast, hu_n, hl_n;
  logic [SW-1:0]         lb_sum [NCOL];
  logic                  lb_tuser [NCOL];
  logic                  lb_tlast [NCOL];
  logic [SW-1:0]         rd_sum, tot, rnd;
  logic                  rd_u, rd_l, tot_u, tot_l;
  logic                  accept, active, grp_done, blk_done;
  logic [D_WIDTH-1:0]    result;

  assign up_ready = ~down_valid | down_ready;
  assign accept   = up_valid & up_ready;
  // Beats before the first start-of-frame are consumed but ignored.
  assign active   = accept & (framelock | up_tuser);

  always_comb begin
    // A start-of-frame beat always restarts the block grid at (0,0).
    px_e     = up_tuser ? '0 : px_cnt;
    row_e    = up_tuser ? '0 : row_cnt;
    col_e    = up_tuser ? '0 : col;
    ovf_e    = up_tuser ? 1'b0 : col_ovf;
    hsum_n   = (px_e == '0) ? HW'(up_data) : hsum + HW'(up_data);
    hu_n     = ((px_e != '0) & h_tuser) | up_tuser;
    hl_n     = ((px_e != '0) & h_tlast) | up_tlast;
    grp_done = active & (px_e == LAST) & ~ovf_e;
    blk_done = grp_done & (row_e == LAST);
    rd_sum   = (row_e == '0) ? '0 : lb_sum[col_e];
    rd_u     = (row_e != '0) & lb_tuser[col_e];
    rd_l     = (row_e != '0) & lb_tlast[col_e];
    tot      = rd_sum + SW'(hsum_n);
    tot_u    = rd_u | hu_n;
    tot_l    = rd_l | hl_n;
    rnd      = tot + HALF;
    result   = D_WIDTH'(rnd >> (2 * SCALE_LOG2));
  end

  always_ff @(posedge clk) begin
    if (grp_done) begin
      lb_sum[col_e]   <= tot;
      lb_tuser[col_e] <= tot_u;
      lb_tlast[col_e] <= tot_l;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_tuser <= 1'b0;
      down_tlast <= 1'b0;
      framelock  <= 1'b0;
      px_cnt     <= '0;
      row_cnt    <= '0;
      col        <= '0;
      col_ovf    <= 1'b0;
      hsum       <= '0;
      h_tuser    <= 1'b0;
      h_tlast    <= 1'b0;
    end else begin
      if (down_valid & down_ready) down_valid <= 1'b0;
      if (blk_done) begin
        down_valid <= 1'b1;
        down_data  <= result;
        down_tuser <= tot_u;
        down_tlast <= tot_l;
      end
      if (accept & up_tuser) framelock <= 1'b1;
      if (active) begin
        hsum    <= hsum_n;
        h_tuser <= hu_n;
        h_tlast <= hl_n;
        if (up_tlast) begin
          px_cnt  <= '0;
          col     <= '0;
          col_ovf <= 1'b0;
          row_cnt <= row_e + 1'b1;
        end else begin
          px_cnt  <= px_e + 1'b1;
          row_cnt <= row_e;
          col     <= col_e;
          col_ovf <= ovf_e;
          // Past the last buffer column the rest of the line is dropped.
          if (grp_done) begin
            if (col_e == COL_LAST) col_ovf <= 1'b1;
            else                   col     <= col_e + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_video_downscaler_nxn.sv
// tb/tb_video_downscaler_nxn.sv - bench for video_downscaler_nxn
// Three instances: F=2 truncate (16 wide), F=2 round, F=4 truncate.
module tb_video_downscaler_nxn;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] up_data [3];
  logic [7:0] down_data [3];
  logic [2:0] up_tuser, up_tlast, up_valid, up_ready;
  logic [2:0] down_tuser, down_tlast, down_valid, down_ready, framelock;

  video_downscaler_nxn #(.D_WIDTH(8), .SCALE_LOG2(1), .MAX_WIDTH(16), .ROUND(0)) u0 (
    .clk(clk), .rst(rst), .up_data(up_data[0]), .up_tuser(up_tuser[0]), .up_tlast(up_tlast[0]),
    .up_valid(up_valid[0]), .up_ready(up_ready[0]), .down_data(down_data[0]),
    .down_tuser(down_tuser[0]), .down_tlast(down_tlast[0]), .down_valid(down_valid[0]),
    .down_ready(down_ready[0]), .framelock(framelock[0]));
  video_downscaler_nxn #(.D_WIDTH(8), .SCALE_LOG2(1), .MAX_WIDTH(1024), .ROUND(1)) u1 (
    .clk(clk), .rst(rst), .up_data(up_data[1]), .up_tuser(up_tuser[1]), .up_tlast(up_tlast[1]),
    .up_valid(up_valid[1]), .up_ready(up_ready[1]), .down_data(down_data[1]),
    .down_tuser(down_tuser[1]), .down_tlast(down_tlast[1]), .down_valid(down_valid[1]),
    .down_ready(down_ready[1]), .framelock(framelock[1]));
  video_downscaler_nxn #(.D_WIDTH(8), .SCALE_LOG2(2), .MAX_WIDTH(1024), .ROUND(0)) u2 (
    .clk(clk), .rst(rst), .up_data(up_data[2]), .up_tuser(up_tuser[2]), .up_tlast(up_tlast[2]),
    .up_valid(up_valid[2]), .up_ready(up_ready[2]), .down_data(down_data[2]),
    .down_tuser(down_tuser[2]), .down_tlast(down_tlast[2]), .down_valid(down_valid[2]),
    .down_ready(down_ready[2]), .framelock(framelock[2]));

  typedef struct { int data; bit tu; bit tl; } exp_t;
  typedef struct { int d; int p0; int p1; int p2; int p3; int exp; } vec_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sbq [3][$];
  int   pix [16][32];
  bit   done;
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int d, input int data, input bit tu, input bit tl);
    exp_t e;
    e.data = data; e.tu = tu; e.tl = tl;
    sbq[d].push_back(e);
  endfunction

  function automatic int blk_avg(input int by, input int bx, input int f, input int rnd);
    int sum = 0;
    for (int i = 0; i < f; i++)
      for (int j = 0; j < f; j++) sum += pix[by*f+i][bx*f+j];
    return rnd ? (sum + f*f/2) / (f*f) : sum / (f*f);
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst && down_valid[d] && down_ready[d]) begin
        if (sbq[d].size() == 0) check($sformatf("unexpected_out_dut%0d", d), 1, 0);
        else begin
          mon_e = sbq[d].pop_front();
          check($sformatf("data_dut%0d", d), int'(down_data[d]), mon_e.data);
          check($sformatf("tuser_dut%0d", d), int'(down_tuser[d]), int'(mon_e.tu));
          check($sformatf("tlast_dut%0d", d), int'(down_tlast[d]), int'(mon_e.tl));
        end
      end
    end
  end

  task automatic send_beat(input int d, input int data, input bit tu, input bit tl);
    int n = 0;
    up_data[d] = 8'(data); up_tuser[d] = tu; up_tlast[d] = tl; up_valid[d] = 1'b1;
    forever begin
      @(negedge clk);
      if (up_ready[d]) break;
      n++;
      if (n > 200) begin check("up_ready_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    up_valid[d] = 1'b0; up_tuser[d] = 1'b0; up_tlast[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input int w, input int h, input int f, input int rnd, input int ncol);
    for (int by = 0; by < h/f; by++)
      for (int bx = 0; bx < w/f && bx < ncol; bx++)
        push(d, blk_avg(by, bx, f, rnd), by == 0 && bx == 0, bx == w/f - 1);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) send_beat(d, pix[y][x], y == 0 && x == 0, x == w - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    for (int d = 0; d < 3; d++) check($sformatf("pending_dut%0d", d), sbq[d].size(), 0);
  endtask

  task automatic fill_random(input int h, input int w);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) pix[y][x] = int'($urandom_range(0, 255));
  endtask

  vec_t tbl [10];
  int   snap_d, snap_u, snap_l, n;
  int   old0, old1;

  initial begin
    rst = 1'b0; up_valid = '0; up_tuser = '0; up_tlast = '0; down_ready = 3'b111;
    for (int d = 0; d < 3; d++) up_data[d] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_valid_dut%0d", d), int'(down_valid[d]), 0);
      check($sformatf("reset_lock_dut%0d", d), int'(framelock[d]), 0);
    end
    @(posedge clk); #1; rst = 1'b1;

    // Lock: pre-frame beats are dropped, then a 4x2 frame.
    for (int i = 0; i < 3; i++) send_beat(0, 7 + i, 0, 0);
    check("lock_before_tuser", int'(framelock[0]), 0);
    push(0, 35, 1, 0);
    push(0, 55, 0, 1);
    send_beat(0, 10, 1, 0);
    check("lock_on_tuser", int'(framelock[0]), 1);
    send_beat(0, 20, 0, 0); send_beat(0, 30, 0, 0); send_beat(0, 40, 0, 1);
    send_beat(0, 50, 0, 0); send_beat(0, 60, 0, 0); send_beat(0, 70, 0, 0); send_beat(0, 80, 0, 1);
    drain();

    // Rounding vectors: each entry is a single 2x2 frame.
    tbl[0] = '{0, 1, 2, 2, 2, 1};
    tbl[1] = '{1, 1, 2, 2, 2, 2};
    tbl[2] = '{1, 255, 255, 255, 255, 255};
    tbl[3] = '{0, 255, 255, 255, 255, 255};
    tbl[4] = '{1, 1, 1, 1, 0, 1};
    tbl[5] = '{0, 1, 1, 1, 0, 0};
    tbl[6] = '{1, 2, 2, 2, 4, 3};
    tbl[7] = '{0, 2, 2, 2, 4, 2};
    tbl[8] = '{1, 3, 3, 3, 4, 3};
    tbl[9] = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      push(tbl[i].d, tbl[i].exp, 1, 1);
      send_beat(tbl[i].d, tbl[i].p0, 1, 0);
      send_beat(tbl[i].d, tbl[i].p1, 0, 1);
      send_beat(tbl[i].d, tbl[i].p2, 0, 0);
      send_beat(tbl[i].d, tbl[i].p3, 0, 1);
    end
    drain();

    // Factor 4: 8x4 frame, one pixel of the first block raised by 16.
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) pix[y][x] = 100;
    pix[1][2] = 116;
    send_frame(2, 8, 4, 4, 0, 256);
    drain();

    // Column overflow: 20-pixel lines into a 16-pixel line buffer.
    fill_random(2, 20);
    send_frame(0, 20, 2, 2, 0, 8);
    drain();

    // Backpressure: 5-cycle hold on the first output, then random stalls.
    fill_random(16, 16);
    done = 1'b0;
    down_ready[0] = 1'b0;
    fork
      begin
        send_frame(0, 16, 16, 2, 0, 8);
        done = 1'b1;
      end
      begin
        n = 0;
        while (!down_valid[0] && n < 400) begin @(negedge clk); n++; end
        check("bp_valid_seen", int'(down_valid[0]), 1);
        @(negedge clk);
        snap_d = int'(down_data[0]); snap_u = int'(down_tuser[0]); snap_l = int'(down_tlast[0]);
        repeat (5) begin
          @(negedge clk);
          check("bp_up_ready", int'(up_ready[0]), 0);
          check("bp_valid_hold", int'(down_valid[0]), 1);
          check("bp_data_hold", int'(down_data[0]), snap_d);
          check("bp_tuser_hold", int'(down_tuser[0]), snap_u);
          check("bp_tlast_hold", int'(down_tlast[0]), snap_l);
        end
        while (!done) begin
          @(posedge clk); #1;
          down_ready[0] = 1'($urandom_range(0, 1));
        end
        down_ready[0] = 1'b1;
      end
    join
    drain();

    // Resync: new start-of-frame at pixel 5 of line 1 of an 8x2 frame.
    fill_random(2, 8);
    old0 = blk_avg(0, 0, 2, 0);
    old1 = blk_avg(0, 1, 2, 0);
    push(0, old0, 1, 0);
    push(0, old1, 0, 0);
    for (int x = 0; x < 8; x++) send_beat(0, pix[0][x], x == 0, x == 7);
    for (int x = 0; x < 5; x++) send_beat(0, pix[1][x], 0, 0);
    fill_random(2, 8);
    send_frame(0, 8, 2, 2, 0, 8);
    drain();

    // Reset while an output is held and an input beat is pending.
    down_ready[0] = 1'b0;
    send_beat(0, 11, 1, 0); send_beat(0, 12, 0, 1); send_beat(0, 13, 0, 0); send_beat(0, 14, 0, 1);
    n = 0;
    while (!down_valid[0] && n < 50) begin @(negedge clk); n++; end
    check("rst_pre_valid", int'(down_valid[0]), 1);
    up_data[0] = 8'd99; up_valid[0] = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_async_valid", int'(down_valid[0]), 0);
    check("rst_async_lock", int'(framelock[0]), 0);
    up_valid[0] = 1'b0;
    down_ready[0] = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    send_beat(0, 40, 0, 0); send_beat(0, 40, 0, 1); send_beat(0, 40, 0, 0); send_beat(0, 40, 0, 1);
    repeat (4) @(negedge clk);
    check("rst_no_out_unlocked", int'(down_valid[0]), 0);
    check("rst_lock_unlocked", int'(framelock[0]), 0);
    push(0, 25, 1, 1);
    send_beat(0, 20, 1, 0); send_beat(0, 30, 0, 1); send_beat(0, 20, 0, 0); send_beat(0, 30, 0, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
